keypad_scan_debounce: RTL and testbench
=======================================

// Module: keypad_scan_debounce
//
// PURPOSE
//   Scans a 4x4 matrix keypad by driving one column high at a time and sampling the rows.
//   Debounces each press and emits one single-cycle key_valid pulse per debounced press,
//   together with its 4-bit hex key_code.
//   Sits directly upstream of the two-digit hex shift/display stage (hex_R/hex_L, seg mux).
//   That stage shifts hex_R->hex_L and loads key_code into hex_R on each key_valid.
//
// PARAMETERS
//   SCAN_DIV         4   clk cycles each column stays driven while scanning (>=3, covers sync delay)
//   DEBOUNCE_CYCLES  16  consecutive stable cycles required to accept a press or a release
//   CNT_W            8   width of the internal scan/debounce counters (must hold max of the above)
//
// PORTS
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-low reset
//   row_keys   in   4  keypad rows; external pulldowns; 1 = key in driven column closed
//   col_keys   out  4  one-hot column drive, active high
//   key_code   out  4  hex value of last accepted key; held until next accept
//   key_valid  out  1  one-cycle strobe: key_code newly accepted this cycle
//
// BEHAVIOUR
//   - Reset (rst=0, async): state=SCAN, col_keys=4'b0001, key_code=4'h0, key_valid=0, counters=0.
//   - row_keys passes through a 2-FF synchronizer (row_s). All decisions use row_s only.
//   - Key map, key_code=map[row][col], col index = one-hot bit position:
//       row0: 1 2 3 A | row1: 4 5 6 B | row2: 7 8 9 C | row3: E 0 F D
//   - SCAN:
//       * col_keys rotates 0001->0010->0100->1000->0001 every SCAN_DIV cycles.
//       * If row_s != 0 while the current column has been driven for >=2 cycles:
//         latch lowest set row index and current column; freeze col_keys; clear count; go DEBOUNCE.
//   - DEBOUNCE:
//       * Each cycle the latched row bit is 1, count++.
//       * If that bit reads 0, return to SCAN with no pulse; scan resumes at the next column.
//       * When count reaches DEBOUNCE_CYCLES-1, load key_code from the map and assert key_valid for exactly 1 cycle.
//       * Then go HOLD.
//   - HOLD: col_keys frozen. Other keys are ignored. When the latched row bit reads 0, clear count and go RELEASE.
//   - RELEASE: count++ while the latched row bit is 0.
//       * If it reads 1, return to HOLD (bounce on release; no new pulse).
//       * At DEBOUNCE_CYCLES-1, go SCAN and advance to the next column.
//   - Latency: row edge -> key_valid = 2 (sync) + DEBOUNCE_CYCLES cycles.
//   - Exactly one key_valid per debounced press, however long it is held.
//     Holding a second key during HOLD never produces a pulse.
//     Release of the first key, then the second still held: the second key is accepted via a fresh SCAN/DEBOUNCE.
//   - Multiple rows set in the same column: lowest row index wins.
//   - key_valid is never high in two consecutive cycles.
//     key_code changes only in the cycle key_valid is asserted.
//   - Reset asserted mid-DEBOUNCE/HOLD: immediately returns to reset values; no pulse is emitted.
//   - col_keys is always exactly one-hot; never 0000 and never multi-hot.
//
// TESTING
//   1. Reset, no keys, 40 cycles -> col_keys cycles 0001,0010,0100,1000 every 4 clk; key_valid stays 0.
//   2. Press row1/col2, hold 60 cycles -> exactly one key_valid pulse with key_code=4'h6, 18 cycles after the row edge.
//   3. Release, then press row2/col3 -> one pulse with key_code=4'hC; key_code holds 6 until that pulse.
//   4. Press row0/col0 for 5 cycles only (< DEBOUNCE_CYCLES) -> no key_valid; key_code unchanged; scanning resumes.
//   5. Hold row3/col1 and toggle it low for 3 cycles mid-hold -> one pulse, key_code=4'h0, no second pulse.
//      Then press row0/col3 while row3/col1 is still held -> no pulse until row3/col1 is released, then key_code=4'hA.
//   6. Drop rst for 1 cycle mid-DEBOUNCE on row2/col0 -> col_keys=0001, key_code=0, key_valid=0 at once;
//      with the key still held, the press is re-accepted afterwards with key_code=4'h7.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: one-hot column drive, 2-FF row synchronizer, and a
// press/release debouncer that emits one key_valid strobe per accepted key.
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_keys,
  output logic [3:0] col_keys,
  output logic [3:0] key_code,
  output logic       key_valid
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_e;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] SETTLED   = CNT_W'(2);
  // Last count before the stable window completes; the transition happens on it.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       row_meta_q, row_s_q;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             row_bit;

  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] lowest_row(input logic [3:0] row);
    logic [1:0] idx;
    casez (row)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  assign row_bit = row_s_q[row_idx_q];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      row_meta_q  <= '0;
      row_s_q     <= '0;
      col_idx_q   <= '0;
      col_cnt_q   <= '0;
      cnt_q       <= '0;
      row_idx_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_meta_q  <= row_keys;
      row_s_q     <= row_meta_q;
      col_idx_q   <= col_idx_d;
      col_cnt_q   <= col_cnt_d;
      cnt_q       <= cnt_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    col_cnt_d   = col_cnt_q;
    cnt_d       = cnt_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        // Rows are only trusted once the sync chain reflects this column.
        if (row_s_q != 4'b0 && col_cnt_q >= SETTLED) begin
          row_idx_d = lowest_row(row_s_q);
          cnt_d     = '0;
          state_d   = DEBOUNCE;
        end else if (col_cnt_q == SCAN_LAST) begin
          col_idx_d = col_idx_q + 2'd1;
          col_cnt_d = '0;
        end else begin
          col_cnt_d = col_cnt_q + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (!row_bit) begin
          col_idx_d = col_idx_q + 2'd1;
          col_cnt_d = '0;
          state_d   = SCAN;
        end else if (cnt_q == DB_LAST) begin
          cnt_d       = cnt_q + CNT_ONE;
          key_code_d  = map_key(row_idx_q, col_idx_q);
          key_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (!row_bit) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (row_bit) begin
          state_d = HOLD;
        end else if (cnt_q == DB_LAST) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          col_cnt_d = '0;
          state_d   = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    col_keys  = 4'b0001 << col_idx_q;
    key_code  = key_code_q;
    key_valid = key_valid_q;
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed + randomized bench for keypad_scan_debounce: a keypad matrix model
// drives the rows, and a scoreboard of expected key codes checks every strobe.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 16;
  localparam int LAT      = 2 + DB;
  localparam logic [3:0] KMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_keys, col_keys, key_code;
  logic        key_valid;
  logic [15:0] pressed = '0;   // bit row*4+col = key closed

  int          n_assert = 0, n_fail = 0, cyc = 0, last_rise = 0;
  logic        lat_chk = 1'b0;
  logic [3:0]  prev_code = '0, prev_row = '0, col_seen = '0;
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_q [$];

  always #5 clk = ~clk;

  // Keypad matrix: a row reads high when a closed key sits in the driven column.
  always_comb begin
    row_keys = '0;
    for (int r = 0; r < 4; r++) row_keys[r] = |(pressed[r*4 +: 4] & col_keys);
  end

  keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_keys (row_keys),
    .col_keys (col_keys),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants and scoreboard, sampled at the falling edge.
  task automatic monitor();
    logic [3:0] e;
    cyc++;
    if (rst) begin
      check("col_onehot", $countones(col_keys), 1);
      check("valid_not_back_to_back", {31'b0, key_valid & prev_valid}, 0);
      if (key_code !== prev_code) check("code_changes_only_with_valid", {31'b0, key_valid}, 1);
      col_seen |= col_keys;
      if (row_keys != 4'b0 && prev_row == 4'b0) last_rise = cyc;
      if (key_valid) begin
        check("pulse_expected", {31'b0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pulse_key_code", key_code, e);
        end
        if (lat_chk) check("row_edge_to_valid_latency", cyc - last_rise, LAT);
      end
    end
    prev_code  = key_code;
    prev_valid = key_valid;
    prev_row   = row_keys;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic press(input int r, input int c);
    pressed[r*4 + c] = 1'b1;
  endtask

  initial begin
    int k;
    logic [3:0] one = 4'b0001;

    repeat (3) @(posedge clk);
    #1;
    check("reset_col", col_keys, 4'b0001);
    check("reset_code", key_code, 4'h0);
    check("reset_valid", {31'b0, key_valid}, 0);
    rst = 1'b1;

    // Idle scan: each column held SCAN_DIV cycles in order, no strobe.
    for (int j = 0; j < 40; j++) begin
      check("idle_col_rotation", col_keys, one << ((j / SCAN_DIV) % 4));
      check("idle_no_valid", {31'b0, key_valid}, 0);
      tick();
    end

    lat_chk = 1'b1;
    run($urandom_range(0, 7));
    exp_q.push_back(4'h6);
    press(1, 2);
    run(60);
    drain("t2_single_pulse", 0);
    check("t2_code", key_code, 4'h6);
    pressed = '0;
    run(30);

    check("t3_code_held", key_code, 4'h6);
    exp_q.push_back(4'hC);
    press(2, 3);
    drain("t3_pulse", 60);
    check("t3_code", key_code, 4'hC);
    pressed = '0;
    run(30);

    // Short press shorter than the debounce window.
    press(0, 0);
    run(5);
    pressed = '0;
    col_seen = '0;
    run(40);
    check("t4_code_unchanged", key_code, 4'hC);
    check("t4_scan_resumes", col_seen, 4'hF);

    // Two rows closed in one column: the lower row index is reported.
    exp_q.push_back(4'h5);
    press(1, 1);
    press(3, 1);
    drain("multirow_pulse", 60);
    check("multirow_code", key_code, 4'h5);
    pressed = '0;
    run(30);

    // Bounce during hold, then a second key held across the first release.
    exp_q.push_back(4'h0);
    press(3, 1);
    drain("t5_first_pulse", 60);
    run(10);
    pressed[13] = 1'b0;
    run(3);
    pressed[13] = 1'b1;
    run(20);
    press(0, 3);
    run(40);
    check("t5_code_held_while_second_key", key_code, 4'h0);
    exp_q.push_back(4'hA);
    pressed[13] = 1'b0;
    drain("t5_second_pulse", 80);
    check("t5_second_code", key_code, 4'hA);
    pressed = '0;
    run(30);

    // Reset in the middle of a debounce, key still held throughout.
    lat_chk = 1'b0;
    k = 0;
    while (col_keys != 4'b1000 && k < 40) begin tick(); k++; end
    check("t6_reach_col3", col_keys, 4'b1000);
    press(2, 0);
    k = 0;
    while (row_keys == 4'b0 && k < 40) begin tick(); k++; end
    check("t6_row_seen", {31'b0, row_keys != 4'b0}, 1);
    run(6);
    rst = 1'b0;
    #1;
    check("t6_reset_col", col_keys, 4'b0001);
    check("t6_reset_code", key_code, 4'h0);
    check("t6_reset_valid", {31'b0, key_valid}, 0);
    tick();
    rst = 1'b1;
    exp_q.push_back(4'h7);
    drain("t6_reaccept_pulse", 60);
    check("t6_reaccept_code", key_code, 4'h7);
    pressed = '0;
    run(30);

    // Random single-key presses with random phase and hold length.
    lat_chk = 1'b1;
    for (int n = 0; n < 8; n++) begin
      int key;
      key = int'($urandom_range(0, 15));
      run($urandom_range(0, 7));
      exp_q.push_back(KMAP[key]);
      pressed[key] = 1'b1;
      run($urandom_range(40, 70));
      drain("rand_pulse", 0);
      check("rand_code", key_code, KMAP[key]);
      pressed = '0;
      run($urandom_range(25, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
